// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: default framing byte, error codes, parser states.
package uart_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_DRAIN
  } parser_state_e;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: one write port, one read port whose address is registered.
module uart_frame_buf #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0]    mem [2**AW];
  logic [AW-1:0] rd_addr_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_addr_q <= rd_addr;
  end

  assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/payload/CSUM frames from the UART byte stream and releases verified
// payloads over a valid/ready stream; malformed, stalled or overrunning frames pulse frame_err.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SOF          = SOF_DEFAULT,
  parameter int         TIMEOUT_CLKS = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CLKS + 1);
  localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);

  parser_state_e    state;
  logic [IDX_W-1:0] len;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] rd_idx_next;
  logic [7:0]       sum;
  logic [7:0]       csum_total;
  logic [TO_W-1:0]  idle_cnt;
  logic [7:0]       buf_rd_data;
  logic             xfer;
  logic             final_xfer;
  logic             buf_wr_en;
  logic             in_frame;

  assign xfer       = out_valid && out_ready;
  assign final_xfer = xfer && out_last;
  assign buf_wr_en  = (state == S_PAYLOAD) && in_valid;
  assign csum_total = sum + in_data;
  assign in_frame   = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
  assign out_data   = out_valid ? buf_rd_data : 8'h00;

  // The buffer registers this address, so the byte for rd_idx is ready the cycle after it changes.
  always_comb begin
    rd_idx_next = rd_idx;
    if (state == S_CSUM && in_valid) begin
      rd_idx_next = '0;
    end else if (xfer) begin
      rd_idx_next = rd_idx + 1'b1;
    end
  end

  uart_frame_buf #(
    .AW(BUF_AW)
  ) u_buf (
    .clk    (clk),
    .wr_en  (buf_wr_en),
    .wr_addr(wr_idx[BUF_AW-1:0]),
    .wr_data(in_data),
    .rd_addr(rd_idx_next[BUF_AW-1:0]),
    .rd_data(buf_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      len       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      sum       <= '0;
      idle_cnt  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      rd_idx    <= rd_idx_next;

      // A byte arriving in the expiry cycle wins over the timeout.
      if (in_frame && !in_valid) begin
        if (idle_cnt == TO_LAST) begin
          idle_cnt  <= '0;
          frame_err <= 1'b1;
          err_code  <= ERR_TIMEOUT;
          state     <= S_IDLE;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end

      unique case (state)
        S_IDLE: begin
          if (in_valid && in_data == SOF) begin
            state <= S_LEN;
          end
        end
        S_LEN: begin
          if (in_valid) begin
            if (in_data == 8'h00 || in_data > MAX_LEN_B) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= S_IDLE;
            end else begin
              len    <= in_data[IDX_W-1:0];
              sum    <= in_data;
              wr_idx <= '0;
              state  <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (in_valid) begin
            wr_idx <= wr_idx + 1'b1;
            sum    <= sum + in_data;
            if (wr_idx == len - 1'b1) begin
              state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (in_valid) begin
            if (csum_total == 8'h00) begin
              frame_ok  <= 1'b1;
              out_valid <= 1'b1;
              out_last  <= (len == IDX_W'(1));
              state     <= S_DRAIN;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CSUM;
              state     <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          // On the final transfer the parser already behaves as IDLE for an incoming byte.
          if (final_xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= (in_valid && in_data == SOF) ? S_LEN : S_IDLE;
          end else begin
            if (xfer) begin
              out_last <= (rd_idx_next == len - 1'b1);
            end
            if (in_valid) begin
              frame_err <= 1'b1;
              err_code  <= ERR_OVERRUN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: table-driven frames, hand-written timing sequences,
// and randomized frame streams checked against a list-level frame model.
module tb_uart_frame_parser;

  localparam int         MAX_LEN      = 16;
  localparam int         TIMEOUT_CLKS = 50;
  localparam logic [7:0] SOF          = 8'hA5;
  localparam int EV_OK   = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_XFER = 2;

  typedef struct {
    int kind;
    int data;
    int last;
    int cyc;
  } ev_t;

  typedef struct {
    string        name;
    int           n;
    logic [159:0] bytes;
    int           exp_ok;
    int           exp_err;
    int           exp_code;
    int           exp_len;
    logic [127:0] exp_pay;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  int   cyc = 0;
  int   last_byte_cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  got[$];
  ev_t  exp_q[$];
  logic [7:0] rand_stream[$];
  vec_t vecs[7];

  uart_frame_parser #(
    .MAX_LEN     (MAX_LEN),
    .SOF         (SOF),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_ok) got.push_back('{EV_OK, 0, 0, cyc});
    if (frame_err) got.push_back('{EV_ERR, int'(err_code), 0, cyc});
    if (out_valid && out_ready) got.push_back('{EV_XFER, int'(out_data), int'(out_last), cyc});
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = b;
    last_byte_cyc = cyc;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic setReady(input logic r);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = r;
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkQuietOutputs(input string tag);
    @(negedge clk);
    checkValue({tag, "_out_valid"}, int'(out_valid), 0);
    checkValue({tag, "_out_last"},  int'(out_last),  0);
    checkValue({tag, "_frame_ok"},  int'(frame_ok),  0);
    checkValue({tag, "_frame_err"}, int'(frame_err), 0);
    checkValue({tag, "_out_data"},  int'(out_data),  0);
    checkValue({tag, "_err_code"},  int'(err_code),  0);
  endtask

  task automatic pulseReset(input int n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    checkQuietOutputs("in_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic void expEv(input int kind, input int data, input int last);
    exp_q.push_back('{kind, data, last, 0});
  endfunction

  task automatic checkOutput(input string name);
    vectors++;
    if (got.size() != exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL %s event_count: got %0d, expected %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      vectors++;
      if (got[i].kind != exp_q[i].kind || got[i].data != exp_q[i].data ||
          got[i].last != exp_q[i].last) begin
        miscompares++;
        $display("[TB] FAIL %s event %0d: got kind=%0d data=%02h last=%0d, expected kind=%0d data=%02h last=%0d",
                 name, i, got[i].kind, got[i].data, got[i].last,
                 exp_q[i].kind, exp_q[i].data, exp_q[i].last);
      end
    end
    got.delete();
    exp_q.delete();
  endtask

  // Reference: walks the byte list frame by frame; a frame cut short by the end of the list times out.
  function automatic void modelStream();
    int i;
    int n;
    int len;
    int s;
    i = 0;
    n = rand_stream.size();
    while (i < n) begin
      if (rand_stream[i] != SOF) begin
        i++;
      end else if (i + 1 >= n) begin
        expEv(EV_ERR, 0, 0);
        i = n;
      end else begin
        len = int'(rand_stream[i+1]);
        if (len == 0 || len > MAX_LEN) begin
          expEv(EV_ERR, 1, 0);
          i += 2;
        end else if (i + 2 + len >= n) begin
          expEv(EV_ERR, 0, 0);
          i = n;
        end else begin
          s = len;
          for (int k = 0; k < len; k++) s += int'(rand_stream[i+2+k]);
          s += int'(rand_stream[i+2+len]);
          if (s % 256 == 0) begin
            expEv(EV_OK, 0, 0);
            for (int k = 0; k < len; k++)
              expEv(EV_XFER, int'(rand_stream[i+2+k]), (k == len - 1) ? 1 : 0);
          end else begin
            expEv(EV_ERR, 2, 0);
          end
          i += len + 3;
        end
      end
    end
  endfunction

  task automatic runRandom(input int units);
    logic [7:0] unit_b[$];
    logic [7:0] b;
    logic [7:0] s;
    int kind;
    int len;
    rand_stream.delete();
    for (int u = 0; u < units; u++) begin
      unit_b.delete();
      kind = (u == units - 1) ? 5 : int'($urandom_range(0, 4));
      case (kind)
        0, 1, 2: begin
          len = int'($urandom_range(1, MAX_LEN));
          unit_b.push_back(SOF);
          unit_b.push_back(8'(len));
          s = 8'(len);
          for (int k = 0; k < len; k++) begin
            b = 8'($urandom_range(0, 255));
            unit_b.push_back(b);
            s = s + b;
          end
          b = 8'h00 - s;
          if (kind == 2) b = b + 8'($urandom_range(1, 255));
          unit_b.push_back(b);
        end
        3: begin
          unit_b.push_back(SOF);
          if ($urandom_range(0, 1) == 0) unit_b.push_back(8'h00);
          else unit_b.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
        end
        4: begin
          len = int'($urandom_range(1, 3));
          for (int k = 0; k < len; k++) begin
            b = 8'($urandom_range(0, 255));
            if (b == SOF) b = 8'h00;
            unit_b.push_back(b);
          end
        end
        default: begin
          unit_b.push_back(SOF);
          unit_b.push_back(8'h05);
          unit_b.push_back(8'($urandom_range(0, 255)));
          unit_b.push_back(8'($urandom_range(0, 255)));
        end
      endcase
      for (int k = 0; k < unit_b.size(); k++) begin
        applyStimulus(unit_b[k]);
        rand_stream.push_back(unit_b[k]);
        idleCycles(int'($urandom_range(0, 3)));
      end
      idleCycles((kind == 5) ? TIMEOUT_CLKS + 20 : MAX_LEN + 4);
    end
    modelStream();
    checkOutput("random_stream");
  endtask

  initial begin
    int k1;
    int k2;
    vecs[0] = '{"good3",   6, 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}), 1, 0, 0, 3, 128'(24'h112233)};
    vecs[1] = '{"badcsum", 5, 160'({8'hA5, 8'h02, 8'h10, 8'h20, 8'h00}),        0, 1, 2, 0, 128'h0};
    vecs[2] = '{"good1",   4, 160'({8'hA5, 8'h01, 8'h7F, 8'h80}),               1, 0, 0, 1, 128'(8'h7F)};
    vecs[3] = '{"len0",    2, 160'({8'hA5, 8'h00}),                             0, 1, 1, 0, 128'h0};
    vecs[4] = '{"len17",   2, 160'({8'hA5, 8'h11}),                             0, 1, 1, 0, 128'h0};
    vecs[5] = '{"noise",   3, 160'({8'h12, 8'h34, 8'h56}),                      0, 0, 0, 0, 128'h0};
    vecs[6] = '{"len16",  19, 160'({8'hA5, 8'h10, 128'h0102030405060708090A0B0C0D0E0F10, 8'h68}),
                1, 0, 0, 16, 128'h0102030405060708090A0B0C0D0E0F10};

    repeat (3) @(posedge clk);
    #1;
    checkQuietOutputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idleCycles(2);
    got.delete();

    $display("[TB] table-driven frames");
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp_ok != 0) begin
        expEv(EV_OK, 0, 0);
        for (int k = 0; k < vecs[i].exp_len; k++)
          expEv(EV_XFER, int'(vecs[i].exp_pay[8*(vecs[i].exp_len-1-k) +: 8]),
                (k == vecs[i].exp_len - 1) ? 1 : 0);
      end
      if (vecs[i].exp_err != 0) expEv(EV_ERR, vecs[i].exp_code, 0);
      for (int b = 0; b < vecs[i].n; b++) applyStimulus(vecs[i].bytes[8*(vecs[i].n-1-b) +: 8]);
      idleCycles(MAX_LEN + 9);
      checkOutput(vecs[i].name);
    end

    $display("[TB] timeout expiry");
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h10);
    k1 = last_byte_cyc;
    idleCycles(TIMEOUT_CLKS + 15);
    checkValue("timeout_delay", (got.size() > 0) ? got[0].cyc - k1 : -1, TIMEOUT_CLKS + 1);
    expEv(EV_ERR, 0, 0);
    checkOutput("timeout");

    $display("[TB] byte in expiry cycle clears timer");
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h10);
    k1 = last_byte_cyc;
    idleCycles(TIMEOUT_CLKS - 1);
    applyStimulus(8'h20);
    k2 = last_byte_cyc;
    checkValue("late_byte_cycle", k2 - k1, TIMEOUT_CLKS);
    idleCycles(TIMEOUT_CLKS + 15);
    checkValue("rearmed_timeout_delay", (got.size() > 0) ? got[0].cyc - k2 : -1, TIMEOUT_CLKS + 1);
    expEv(EV_ERR, 0, 0);
    checkOutput("timer_clear");

    $display("[TB] overrun under backpressure");
    setReady(1'b0);
    applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'h11);
    applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h97);
    idleCycles(3);
    @(negedge clk);
    checkValue("stall_out_valid", int'(out_valid), 1);
    checkValue("stall_out_data", int'(out_data), 'h11);
    applyStimulus(8'h55);
    idleCycles(3);
    @(negedge clk);
    checkValue("overrun_out_data", int'(out_data), 'h11);
    checkValue("overrun_out_last", int'(out_last), 0);
    setReady(1'b1);
    idleCycles(10);
    expEv(EV_OK, 0, 0);
    expEv(EV_ERR, 3, 0);
    expEv(EV_XFER, 'h11, 0);
    expEv(EV_XFER, 'h22, 0);
    expEv(EV_XFER, 'h33, 1);
    checkOutput("overrun");

    $display("[TB] reset mid-frame");
    applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'h11);
    pulseReset(2);
    idleCycles(TIMEOUT_CLKS + 10);
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h7F); applyStimulus(8'h80);
    idleCycles(8);
    expEv(EV_OK, 0, 0);
    expEv(EV_XFER, 'h7F, 1);
    checkOutput("reset_midframe");

    $display("[TB] reset during stalled drain");
    setReady(1'b0);
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h7F); applyStimulus(8'h80);
    idleCycles(2);
    @(negedge clk);
    checkValue("predrain_out_valid", int'(out_valid), 1);
    pulseReset(2);
    setReady(1'b1);
    idleCycles(8);
    expEv(EV_OK, 0, 0);
    checkOutput("reset_drain");

    $display("[TB] SOF during final transfer");
    applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'hAA);
    applyStimulus(8'hBB); applyStimulus(8'h99);
    idleCycles(1);
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h7F); applyStimulus(8'h80);
    idleCycles(10);
    expEv(EV_OK, 0, 0);
    expEv(EV_XFER, 'hAA, 0);
    expEv(EV_XFER, 'hBB, 1);
    expEv(EV_OK, 0, 0);
    expEv(EV_XFER, 'h7F, 1);
    checkOutput("back_to_back");

    $display("[TB] randomized frame stream");
    runRandom(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Downstream stage of the UART receiver. Consumes the received byte stream (one `in_valid` strobe per byte) and parses framed packets of the form SOF, LEN, LEN payload bytes, CSUM. Payload is held in a local buffer until the checksum verifies, then released to the command logic over a valid/ready stream. Malformed, stalled or overrunning frames are reported as single-cycle error pulses with a code.

## Interface
Parameters:
- `MAX_LEN`, default 16: largest accepted payload length, valid range 1..255.
- `SOF`, default 8'hA5: start-of-frame byte.
- `TIMEOUT_CLKS`, default 100000: idle cycles allowed between bytes inside a frame.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: one-cycle strobe meaning a received byte is on `in_data`. No backpressure is possible on this input.
- `in_data` in 8: received byte.
- `out_valid` out 1: a payload byte is available.
- `out_data` out 8: payload byte.
- `out_last` out 1: the current byte is the final payload byte.
- `out_ready` in 1: downstream accepts the byte; a transfer occurs when `out_valid && out_ready`.
- `frame_ok` out 1: one-cycle pulse, frame passed the checksum.
- `frame_err` out 1: one-cycle pulse, error detected.
- `err_code` out 2: error cause, valid while `frame_err` is high. 0 = timeout, 1 = bad length, 2 = bad checksum, 3 = overrun.

## Operation
- States: IDLE, LEN, PAYLOAD, CSUM, DRAIN.
- **IDLE**
  - An `in_valid` byte equal to SOF moves to LEN.
  - Any other byte is ignored silently, with no error.
- **LEN**
  - Byte 0 or a byte greater than MAX_LEN raises err 1 and returns to IDLE.
  - Otherwise, store the length, seed `sum` with the length byte, clear the write index, and move to PAYLOAD.
- **PAYLOAD**
  - Each byte is written to `buf[wr_idx]`, then `wr_idx` is incremented and `sum` is incremented by the byte.
  - After LEN bytes, move to CSUM.
- **CSUM**
  - Checksum rule: `(sum + byte) mod 256` must equal 0.
  - On a match: pulse `frame_ok`, clear `rd_idx`, and move to DRAIN.
  - On a mismatch: raise err 2 and return to IDLE.
- **DRAIN**
  - `out_valid` = 1, `out_data` = `buf[rd_idx]`, `out_last` = (`rd_idx` == len-1).
  - Each transfer increments `rd_idx`.
  - The transfer with `out_last` set returns to IDLE.
- **Overrun**
  - An `in_valid` byte arriving in DRAIN is dropped and raises err 3, one pulse per dropped byte.
  - Buffer contents and drain progress are unaffected.
- **Final transfer cycle**
  - On the cycle of the final DRAIN transfer, an `in_valid` byte is treated as if the parser were in IDLE: SOF is accepted and moves to LEN; any other byte is ignored.
  - No overrun is raised for that byte.
- **Timeout**
  - In LEN, PAYLOAD and CSUM, an idle counter clears on every accepted byte and increments on every cycle without `in_valid`.
  - When the counter reaches TIMEOUT_CLKS, raise err 0 and return to IDLE.
  - An `in_valid` in the expiry cycle wins: the byte is processed and the counter clears.
- **Width rules**
  - Length register and indices are `$clog2(MAX_LEN+1)` bits.
  - `sum` is 8 bits and wraps modulo 256.
  - Idle counter is `$clog2(TIMEOUT_CLKS+1)` bits.
- **Reset mid-operation**: return to IDLE, clear all counters and outputs, emit no pulses, and abandon any partial frame or undrained payload.

## Timing
- Reset values: `out_valid`, `out_last`, `frame_ok`, `frame_err` are 0; `out_data` and `err_code` are 0.
- `frame_ok`, `frame_err` and `err_code` are registered and high for exactly one cycle.
- CSUM byte accepted in cycle t:
  - `frame_ok` and first `out_valid` are high in cycle t+1.
  - Error pulses are in cycle t+1.
- Last byte accepted in cycle t with no further input: err 0 pulses in cycle t+TIMEOUT_CLKS+1.
- In DRAIN, `out_data` and `out_last` update in the cycle after each transfer. With `out_ready` held at 1, a LEN-byte payload drains in exactly LEN cycles.
- `out_valid` stays high and `out_data` stays stable until the transfer completes.
- Minimum frame spacing: none beyond the final-transfer rule; back-to-back frames are accepted when the drain keeps up.

## Structure
- Shared package `uart_pkg`:
  - default SOF constant;
  - `err_code` constants ERR_TIMEOUT, ERR_LEN, ERR_CSUM, ERR_OVERRUN;
  - parser state enum.
- One sub-module, `uart_frame_buf`: MAX_LEN x 8 register array with one write port and one read port, with the read address registered.
- FSM, checksum, timeout counter and stream output live in `uart_frame_parser`.

## Test plan
- **Good frame**: A5 03 11 22 33 97 with `out_ready`=1 -> `frame_ok` once; out 11, 22, 33 with `out_last` on 33; no `frame_err`.
- **Bad checksum**: A5 02 10 20 00 -> err 2 one cycle after the 00; no `out_valid`; next good frame parses normally.
- **Length bounds**, MAX_LEN=16:
  - A5 00 -> err 1.
  - A5 11 -> err 1.
  - A5 10 + 16 bytes + correct CSUM -> 16 outputs, `out_last` on the 16th.
- **Timeout**, TIMEOUT_CLKS=50: A5 02 10, then silence -> err 0 exactly 51 cycles after the 10; a byte at cycle 50 instead clears the timer.
- **Overrun and backpressure**: good frame, `out_ready`=0, inject 55 -> err 3 and payload unchanged; then `out_ready`=1 -> full payload is delivered.
- **Mid-frame reset, then back-to-back frames**:
  - Reset after A5 03 11 -> all outputs 0 and no pulses; a following good frame works.
  - A SOF during the final transfer starts the next frame.
